// File: rtl/rsv_station.sv
// Reservation station for non-memory instructions.
// Holds up to RS_SIZE dispatched instructions, captures missing source operands
// from the ALU and LSB result broadcasts, and issues at most one ready entry per
// cycle (lowest index first) to the ALU.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rdy                 global enable; low freezes every register
//   DP_*                dispatch request and payload from the Dispatcher
//   RS_full             no free entry (from registered state only)
//   ALU_CDB_*, LSB_CDB_* result broadcasts used for operand wakeup
//   ROB_clear           mispredict flush; empties the station
//   ALU_*               registered issue payload towards the ALU
module rsv_station #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OPID_W  = 6,
  parameter int unsigned XLEN    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,

  input  logic              DP_valid,
  input  logic [OPID_W-1:0] DP_op_id,
  input  logic [XLEN-1:0]   DP_pc,
  input  logic [XLEN-1:0]   DP_imm,
  input  logic [TAG_W-1:0]  DP_rd_tag,
  input  logic              DP_qj_busy,
  input  logic [TAG_W-1:0]  DP_qj,
  input  logic [XLEN-1:0]   DP_vj,
  input  logic              DP_qk_busy,
  input  logic [TAG_W-1:0]  DP_qk,
  input  logic [XLEN-1:0]   DP_vk,
  output logic              RS_full,

  input  logic              ALU_CDB_valid,
  input  logic [TAG_W-1:0]  ALU_CDB_tag,
  input  logic [XLEN-1:0]   ALU_CDB_value,
  input  logic              LSB_CDB_valid,
  input  logic [TAG_W-1:0]  LSB_CDB_tag,
  input  logic [XLEN-1:0]   LSB_CDB_value,

  input  logic              ROB_clear,

  output logic              ALU_valid,
  output logic [OPID_W-1:0] ALU_op_id,
  output logic [XLEN-1:0]   ALU_pc,
  output logic [XLEN-1:0]   ALU_imm,
  output logic [XLEN-1:0]   ALU_vj,
  output logic [XLEN-1:0]   ALU_vk,
  output logic [TAG_W-1:0]  ALU_rd_tag
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic              busy;
    logic [OPID_W-1:0] op_id;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [TAG_W-1:0]  rd_tag;
    logic              qj_busy;
    logic [TAG_W-1:0]  qj;
    logic [XLEN-1:0]   vj;
    logic              qk_busy;
    logic [TAG_W-1:0]  qk;
    logic [XLEN-1:0]   vk;
  } entry_t;

  entry_t            ent_q [RS_SIZE];
  entry_t            ent_d [RS_SIZE];

  logic              alu_valid_q,  alu_valid_d;
  logic [OPID_W-1:0] alu_op_id_q,  alu_op_id_d;
  logic [XLEN-1:0]   alu_pc_q,     alu_pc_d;
  logic [XLEN-1:0]   alu_imm_q,    alu_imm_d;
  logic [XLEN-1:0]   alu_vj_q,     alu_vj_d;
  logic [XLEN-1:0]   alu_vk_q,     alu_vk_d;
  logic [TAG_W-1:0]  alu_rd_tag_q, alu_rd_tag_d;

  logic              full_c;
  logic              free_found_c;
  logic [IDX_W-1:0]  free_idx_c;
  logic              iss_found_c;
  logic [IDX_W-1:0]  iss_idx_c;

  // Returns {still_pending, value} after snooping both broadcasts; ALU wins a tie.
  function automatic logic [XLEN:0] resolve(input logic             pend,
                                            input logic [TAG_W-1:0] tag,
                                            input logic [XLEN-1:0]  val);
    if (pend && ALU_CDB_valid && (ALU_CDB_tag == tag)) begin
      return {1'b0, ALU_CDB_value};
    end else if (pend && LSB_CDB_valid && (LSB_CDB_tag == tag)) begin
      return {1'b0, LSB_CDB_value};
    end
    return {pend, val};
  endfunction

  // Free-slot and ready-slot priority pickers, both lowest index first.
  always_comb begin
    full_c       = 1'b1;
    free_found_c = 1'b0;
    free_idx_c   = '0;
    iss_found_c  = 1'b0;
    iss_idx_c    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!ent_q[i].busy) begin
        full_c = 1'b0;
        if (!free_found_c) begin
          free_found_c = 1'b1;
          free_idx_c   = IDX_W'(i);
        end
      end
      if (ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy && !iss_found_c) begin
        iss_found_c = 1'b1;
        iss_idx_c   = IDX_W'(i);
      end
    end
  end

  // Next state: flush, or wakeup + issue + dispatch.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
    end
    alu_valid_d  = 1'b0;
    alu_op_id_d  = alu_op_id_q;
    alu_pc_d     = alu_pc_q;
    alu_imm_d    = alu_imm_q;
    alu_vj_d     = alu_vj_q;
    alu_vk_d     = alu_vk_q;
    alu_rd_tag_d = alu_rd_tag_q;

    if (ROB_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy    = 1'b0;
        ent_d[i].qj_busy = 1'b0;
        ent_d[i].qk_busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy) begin
          {ent_d[i].qj_busy, ent_d[i].vj} = resolve(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
          {ent_d[i].qk_busy, ent_d[i].vk} = resolve(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
        end
      end

      // The issued entry had no pending operand, so the wakeup above left it untouched.
      if (iss_found_c) begin
        alu_valid_d            = 1'b1;
        alu_op_id_d            = ent_q[iss_idx_c].op_id;
        alu_pc_d               = ent_q[iss_idx_c].pc;
        alu_imm_d              = ent_q[iss_idx_c].imm;
        alu_vj_d               = ent_q[iss_idx_c].vj;
        alu_vk_d               = ent_q[iss_idx_c].vk;
        alu_rd_tag_d           = ent_q[iss_idx_c].rd_tag;
        ent_d[iss_idx_c].busy  = 1'b0;
      end

      // A request while full finds no free slot and is dropped.
      if (DP_valid && free_found_c) begin
        ent_d[free_idx_c].busy   = 1'b1;
        ent_d[free_idx_c].op_id  = DP_op_id;
        ent_d[free_idx_c].pc     = DP_pc;
        ent_d[free_idx_c].imm    = DP_imm;
        ent_d[free_idx_c].rd_tag = DP_rd_tag;
        ent_d[free_idx_c].qj     = DP_qj;
        ent_d[free_idx_c].qk     = DP_qk;
        {ent_d[free_idx_c].qj_busy, ent_d[free_idx_c].vj} = resolve(DP_qj_busy, DP_qj, DP_vj);
        {ent_d[free_idx_c].qk_busy, ent_d[free_idx_c].vk} = resolve(DP_qk_busy, DP_qk, DP_vk);
      end
    end
  end

  // State registers; rdy low holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      alu_valid_q  <= 1'b0;
      alu_op_id_q  <= '0;
      alu_pc_q     <= '0;
      alu_imm_q    <= '0;
      alu_vj_q     <= '0;
      alu_vk_q     <= '0;
      alu_rd_tag_q <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      alu_valid_q  <= alu_valid_d;
      alu_op_id_q  <= alu_op_id_d;
      alu_pc_q     <= alu_pc_d;
      alu_imm_q    <= alu_imm_d;
      alu_vj_q     <= alu_vj_d;
      alu_vk_q     <= alu_vk_d;
      alu_rd_tag_q <= alu_rd_tag_d;
    end
  end

  assign RS_full    = full_c;
  assign ALU_valid  = alu_valid_q;
  assign ALU_op_id  = alu_op_id_q;
  assign ALU_pc     = alu_pc_q;
  assign ALU_imm    = alu_imm_q;
  assign ALU_vj     = alu_vj_q;
  assign ALU_vk     = alu_vk_q;
  assign ALU_rd_tag = alu_rd_tag_q;

endmodule

// File: tb/tb_rsv_station.sv
// Self-checking bench for rsv_station: expected issues are queued at dispatch
// time and compared by a monitor whenever the station issues.
module tb_rsv_station;

  localparam int unsigned RS_SIZE = 16;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned OPID_W  = 6;
  localparam int unsigned XLEN    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              DP_valid;
  logic [OPID_W-1:0] DP_op_id;
  logic [XLEN-1:0]   DP_pc, DP_imm, DP_vj, DP_vk;
  logic [TAG_W-1:0]  DP_rd_tag, DP_qj, DP_qk;
  logic              DP_qj_busy, DP_qk_busy;
  logic              RS_full;
  logic              ALU_CDB_valid, LSB_CDB_valid;
  logic [TAG_W-1:0]  ALU_CDB_tag, LSB_CDB_tag;
  logic [XLEN-1:0]   ALU_CDB_value, LSB_CDB_value;
  logic              ROB_clear;
  logic              ALU_valid;
  logic [OPID_W-1:0] ALU_op_id;
  logic [XLEN-1:0]   ALU_pc, ALU_imm, ALU_vj, ALU_vk;
  logic [TAG_W-1:0]  ALU_rd_tag;

  rsv_station #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .OPID_W(OPID_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .DP_valid(DP_valid), .DP_op_id(DP_op_id), .DP_pc(DP_pc), .DP_imm(DP_imm),
    .DP_rd_tag(DP_rd_tag), .DP_qj_busy(DP_qj_busy), .DP_qj(DP_qj), .DP_vj(DP_vj),
    .DP_qk_busy(DP_qk_busy), .DP_qk(DP_qk), .DP_vk(DP_vk), .RS_full(RS_full),
    .ALU_CDB_valid(ALU_CDB_valid), .ALU_CDB_tag(ALU_CDB_tag), .ALU_CDB_value(ALU_CDB_value),
    .LSB_CDB_valid(LSB_CDB_valid), .LSB_CDB_tag(LSB_CDB_tag), .LSB_CDB_value(LSB_CDB_value),
    .ROB_clear(ROB_clear),
    .ALU_valid(ALU_valid), .ALU_op_id(ALU_op_id), .ALU_pc(ALU_pc), .ALU_imm(ALU_imm),
    .ALU_vj(ALU_vj), .ALU_vk(ALU_vk), .ALU_rd_tag(ALU_rd_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OPID_W-1:0] op_id;
    logic [XLEN-1:0]   pc, imm, vj, vk;
    logic [TAG_W-1:0]  rd_tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   issued_cnt = 0;
  int   base;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Compares every live issue against the head of the scoreboard.
  always @(posedge clk) begin
    logic live;
    exp_t e;
    live = rdy && rst;
    #1;
    if (live && ALU_valid) begin
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("iss_op_id",  32'(ALU_op_id),  32'(e.op_id));
        check_eq("iss_pc",     ALU_pc,          e.pc);
        check_eq("iss_imm",    ALU_imm,         e.imm);
        check_eq("iss_vj",     ALU_vj,          e.vj);
        check_eq("iss_vk",     ALU_vk,          e.vk);
        check_eq("iss_rd_tag", 32'(ALU_rd_tag), 32'(e.rd_tag));
      end
      issued_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_issue(input logic [OPID_W-1:0] op, input logic [XLEN-1:0] pc,
                              input logic [XLEN-1:0] imm, input logic [XLEN-1:0] vj,
                              input logic [XLEN-1:0] vk, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.op_id = op; e.pc = pc; e.imm = imm; e.vj = vj; e.vk = vk; e.rd_tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic disp(input logic [OPID_W-1:0] op, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] tag,
                      input logic qjb, input logic [TAG_W-1:0] qj, input logic [XLEN-1:0] vj,
                      input logic qkb, input logic [TAG_W-1:0] qk, input logic [XLEN-1:0] vk);
    DP_valid = 1'b1; DP_op_id = op; DP_pc = pc; DP_imm = imm; DP_rd_tag = tag;
    DP_qj_busy = qjb; DP_qj = qj; DP_vj = vj;
    DP_qk_busy = qkb; DP_qk = qk; DP_vk = vk;
    step();
    DP_valid = 1'b0;
  endtask

  task automatic wait_issues(input int target, input int budget);
    int n = 0;
    while (issued_cnt < target && n < budget) begin
      step();
      n++;
    end
    check_eq("issue_count", 32'(issued_cnt), 32'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; ROB_clear = 1'b0;
    DP_valid = 1'b0; DP_op_id = '0; DP_pc = '0; DP_imm = '0; DP_rd_tag = '0;
    DP_qj_busy = 1'b0; DP_qj = '0; DP_vj = '0; DP_qk_busy = 1'b0; DP_qk = '0; DP_vk = '0;
    ALU_CDB_valid = 1'b0; ALU_CDB_tag = '0; ALU_CDB_value = '0;
    LSB_CDB_valid = 1'b0; LSB_CDB_tag = '0; LSB_CDB_value = '0;

    // Reset values
    #12;
    check_eq("rst_alu_valid", 32'(ALU_valid), 32'd0);
    check_eq("rst_full",      32'(RS_full),   32'd0);
    check_eq("rst_alu_vj",    ALU_vj,         32'd0);
    check_eq("rst_alu_pc",    ALU_pc,         32'd0);
    check_eq("rst_alu_tag",   32'(ALU_rd_tag), 32'd0);
    rst = 1'b1;
    step();

    // Asynchronous reset mid-operation: third entry must vanish
    expect_issue(6'd1, 32'h100, 32'd1, 32'h11, 32'h12, 4'd1);
    disp(6'd1, 32'h100, 32'd1, 4'd1, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h12);
    expect_issue(6'd2, 32'h104, 32'd2, 32'h21, 32'h22, 4'd2);
    disp(6'd2, 32'h104, 32'd2, 4'd2, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 32'h22);
    disp(6'd3, 32'h108, 32'd3, 4'd3, 1'b0, 4'd0, 32'h31, 1'b0, 4'd0, 32'h32);
    check_eq("pre_rst_valid", 32'(ALU_valid), 32'd1);
    #3; rst = 1'b0; #1;
    check_eq("async_rst_valid", 32'(ALU_valid), 32'd0);
    check_eq("async_rst_full",  32'(RS_full),   32'd0);
    check_eq("async_rst_vj",    ALU_vj,         32'd0);
    #10; rst = 1'b1;
    step();
    repeat (4) step();
    check_eq("no_issue_after_rst", 32'(issued_cnt), 32'd2);

    // Ready dispatch: written on first edge, issued on second
    base = issued_cnt;
    expect_issue(6'd5, 32'h200, 32'h0, 32'h10, 32'h20, 4'd3);
    disp(6'd5, 32'h200, 32'h0, 4'd3, 1'b0, 4'd0, 32'h10, 1'b0, 4'd0, 32'h20);
    check_eq("rdy_lat_e1", 32'(ALU_valid), 32'd0);
    step();
    check_eq("rdy_lat_e2", 32'(ALU_valid), 32'd1);
    check_eq("rdy_cnt",    32'(issued_cnt), 32'(base + 1));
    step();
    check_eq("rdy_drop",   32'(ALU_valid), 32'd0);

    // Wakeup from the LSB broadcast
    expect_issue(6'd6, 32'h300, 32'h7, 32'hABCD, 32'h4, 4'd4);
    disp(6'd6, 32'h300, 32'h7, 4'd4, 1'b1, 4'd7, 32'hDEAD, 1'b0, 4'd0, 32'h4);
    repeat (3) step();
    check_eq("wake_wait", 32'(ALU_valid), 32'd0);
    LSB_CDB_valid = 1'b1; LSB_CDB_tag = 4'd7; LSB_CDB_value = 32'hABCD;
    step();
    LSB_CDB_valid = 1'b0;
    check_eq("wake_e1", 32'(ALU_valid), 32'd0);
    step();
    check_eq("wake_e2", 32'(ALU_valid), 32'd1);
    check_eq("wake_vj", ALU_vj, 32'hABCD);

    // Same-cycle forwarding from the ALU broadcast into the dispatched entry
    expect_issue(6'd7, 32'h400, 32'h8, 32'h33, 32'd9, 4'd5);
    ALU_CDB_valid = 1'b1; ALU_CDB_tag = 4'd2; ALU_CDB_value = 32'd9;
    disp(6'd7, 32'h400, 32'h8, 4'd5, 1'b0, 4'd0, 32'h33, 1'b1, 4'd2, 32'hBEEF);
    ALU_CDB_valid = 1'b0;
    step();
    check_eq("fwd_issue", 32'(ALU_valid), 32'd1);
    check_eq("fwd_vk",    ALU_vk,         32'd9);

    // Fill all entries blocked on tag 1, overflow attempt, then release in order
    step();
    base = issued_cnt;
    for (int i = 0; i < RS_SIZE; i++) begin
      expect_issue(OPID_W'(i + 8), 32'h1000 + 32'(4 * i), 32'(i), 32'h55, 32'(i + 100), TAG_W'(i));
      disp(OPID_W'(i + 8), 32'h1000 + 32'(4 * i), 32'(i), TAG_W'(i),
           1'b1, 4'd1, 32'h0, 1'b0, 4'd0, 32'(i + 100));
    end
    check_eq("full_set", 32'(RS_full), 32'd1);
    disp(6'd63, 32'hFFFF, 32'hFFFF, 4'd15, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h99);
    check_eq("full_hold",   32'(RS_full),    32'd1);
    check_eq("full_no_iss", 32'(issued_cnt), 32'(base));
    ALU_CDB_valid = 1'b1; ALU_CDB_tag = 4'd1; ALU_CDB_value = 32'h55;
    step();
    ALU_CDB_valid = 1'b0;
    check_eq("full_after_wake", 32'(RS_full), 32'd1);
    step();
    check_eq("full_drop", 32'(RS_full), 32'd0);
    wait_issues(base + RS_SIZE, 40);
    repeat (3) step();
    check_eq("full_no_extra", 32'(issued_cnt), 32'(base + RS_SIZE));

    // Flush with simultaneous dispatch, wakeup and a pending issue
    base = issued_cnt;
    for (int i = 0; i < 3; i++) begin
      disp(6'd20, 32'h2000 + 32'(i), 32'd0, 4'd6, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1);
    end
    disp(6'd21, 32'h2100, 32'd0, 4'd7, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd6);
    ROB_clear = 1'b1;
    ALU_CDB_valid = 1'b1; ALU_CDB_tag = 4'd9; ALU_CDB_value = 32'h77;
    disp(6'd22, 32'h2200, 32'd0, 4'd8, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd8);
    ROB_clear = 1'b0;
    check_eq("flush_valid", 32'(ALU_valid), 32'd0);
    check_eq("flush_full",  32'(RS_full),   32'd0);
    step();
    ALU_CDB_valid = 1'b0;
    repeat (4) step();
    check_eq("flush_no_issue", 32'(issued_cnt), 32'(base));

    // Freeze with rdy low: outputs hold, nothing issues or enters
    base = issued_cnt;
    expect_issue(6'd30, 32'h3000, 32'd1, 32'hA1, 32'hA2, 4'd9);
    disp(6'd30, 32'h3000, 32'd1, 4'd9, 1'b0, 4'd0, 32'hA1, 1'b0, 4'd0, 32'hA2);
    expect_issue(6'd31, 32'h3004, 32'd2, 32'hB1, 32'hB2, 4'd10);
    disp(6'd31, 32'h3004, 32'd2, 4'd10, 1'b0, 4'd0, 32'hB1, 1'b0, 4'd0, 32'hB2);
    check_eq("frz_pre_valid", 32'(ALU_valid), 32'd1);
    rdy = 1'b0;
    DP_valid = 1'b1; DP_op_id = 6'd32; DP_pc = 32'h3008; DP_rd_tag = 4'd11;
    DP_qj_busy = 1'b0; DP_vj = 32'hC1; DP_qk_busy = 1'b0; DP_vk = 32'hC2;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("frz_valid", 32'(ALU_valid), 32'd1);
      check_eq("frz_vj",    ALU_vj,         32'hA1);
    end
    check_eq("frz_no_issue", 32'(issued_cnt), 32'(base + 1));
    DP_valid = 1'b0;
    rdy = 1'b1;
    step();
    check_eq("thaw_vj",  ALU_vj,            32'hB1);
    check_eq("thaw_cnt", 32'(issued_cnt),   32'(base + 2));
    repeat (3) step();
    check_eq("thaw_no_extra", 32'(issued_cnt), 32'(base + 2));
    check_eq("sb_drained",    32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rsv_station.md
Name: rsv_station

Overview:
- Reservation station sitting directly downstream of the Dispatcher. It holds up to RS_SIZE non-memory instructions until both source operands are available.
- Operands are captured from the two CDB broadcasts (ALU and LSB).
- Each cycle, at most one ready entry issues to the ALU.
- The block presents a full flag back to the Dispatcher and flushes completely on a ROB clear.

Parameters:
- RS_SIZE, 16, number of entries.
- TAG_W, 4, ROB tag width.
- OPID_W, 6, opcode-ID width (matches decoder OP_ID bus).
- XLEN, 32, data, address and immediate width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low = freeze all state.
- DP_valid  in  1  dispatch request this cycle.
- DP_op_id  in  OPID_W  operation ID.
- DP_pc  in  XLEN  instruction PC.
- DP_imm  in  XLEN  immediate.
- DP_rd_tag  in  TAG_W  destination ROB tag.
- DP_qj_busy  in  1  rs1 operand still pending.
- DP_qj  in  TAG_W  rs1 producer tag (valid if DP_qj_busy).
- DP_vj  in  XLEN  rs1 value (valid if !DP_qj_busy).
- DP_qk_busy, DP_qk, DP_vk  in  1/TAG_W/XLEN  same, for rs2.
- RS_full  out  1  to Dispatcher; no free entry.
- ALU_CDB_valid, ALU_CDB_tag, ALU_CDB_value  in  1/TAG_W/XLEN  ALU result broadcast.
- LSB_CDB_valid, LSB_CDB_tag, LSB_CDB_value  in  1/TAG_W/XLEN  load result broadcast.
- ROB_clear  in  1  mispredict flush.
- ALU_valid  out  1  issued instruction valid.
- ALU_op_id  out  OPID_W  issued operation ID.
- ALU_pc  out  XLEN  issued PC.
- ALU_imm  out  XLEN  issued immediate.
- ALU_vj  out  XLEN  issued rs1 value.
- ALU_vk  out  XLEN  issued rs2 value.
- ALU_rd_tag  out  TAG_W  issued destination tag.

Behaviour:
- Entry state:
  - busy bit, op_id, pc, imm, rd_tag.
  - qj_busy/qj/vj and qk_busy/qk/vk.
  - Tag value 0 is a legal tag; the busy flags alone indicate pending operands.
- Reset (rst=0, asynchronous):
  - All busy and q*_busy bits are 0.
  - ALU_valid = 0; all other ALU_* outputs = 0.
  - RS_full = 0.
- Priority order: reset > rdy=0 > ROB_clear > normal operation.
- rdy=0: no register changes; outputs hold their last values.
- ROB_clear=1 (with rdy=1):
  - Next edge clears every busy bit and sets ALU_valid = 0.
  - Dispatch, wakeup and issue in that cycle are discarded.
- RS_full:
  - Combinational from registered state: 1 iff all RS_SIZE entries are busy.
  - A same-cycle issue does not lower it.
  - DP_valid while RS_full=1 is a protocol violation; the request is dropped and no entry is overwritten.
- Dispatch:
  - When DP_valid=1, the request is written into the lowest-index free entry.
  - Same-cycle CDB forwarding: if DP_qj_busy and a valid CDB tag equals DP_qj, store qj_busy=0 and vj=CDB value. Same rule for k.
- Wakeup:
  - Every busy entry with qj_busy/qk_busy and a tag match on a valid CDB clears the busy flag and latches the value.
  - Both CDBs are compared in parallel.
  - If both CDBs carry the same tag (illegal), the ALU CDB value wins.
- Issue selection:
  - Uses registered state only: the lowest-index entry with busy=1 and qj_busy=0 and qk_busy=0.
  - On the edge, ALU_* are loaded with that entry, ALU_valid=1, and the entry's busy is cleared.
  - If no entry is ready, ALU_valid=0 and the other ALU_* outputs hold.
- Latency:
  - A dispatched entry with both operands ready issues at the earliest on the 2nd edge after dispatch (written on edge N, ALU_valid high after edge N+1).
  - An entry woken by a CDB on cycle N issues at the earliest after edge N+1.
- Throughput: one dispatch and one issue per cycle, simultaneously, to different entries.
- Entry freed by issue on edge N is available to dispatch in cycle N+1.

Test Plan:
- Reset mid-operation: fill 3 entries, pull rst low asynchronously between edges → ALU_valid=0 and RS_full=0 immediately; nothing issues after release.
- Ready dispatch:
  - Stimulus: op_id=5, vj=0x10, vk=0x20, rd_tag=3, both ready, at cycle 0.
  - Response: ALU_valid=1 after edge 1 with ALU_vj=0x10, ALU_vk=0x20, ALU_rd_tag=3; ALU_valid=0 the cycle after.
- Wakeup:
  - Stimulus: dispatch with qj_busy=1, qj=7, vk=4; three cycles later drive LSB_CDB tag 7, value 0xABCD.
  - Response: issue on the following edge with ALU_vj=0xABCD.
- Same-cycle forward: dispatch qk_busy=1, qk=2 while ALU_CDB_valid tag 2, value 9 → entry stored ready; issues next edge with ALU_vk=9.
- Full and order:
  - Stimulus: dispatch 16 entries all blocked on tag 1.
  - Response: RS_full=1.
  - Stimulus: broadcast tag 1.
  - Response: entries issue one per cycle in index order 0..15; RS_full drops after the first issue.
- Flush: 4 pending entries plus ROB_clear with a simultaneous DP_valid and CDB → after edge, all entries empty, ALU_valid=0, no later issue. rdy=0 for 5 cycles with ready entries → no issue and state unchanged.
